multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore/Mealy control FSM that sequences the shared multi-cycle datapath: one memory port, one ALU, IR, PC and register file.
- Consumes the opcode and zero-instruction flag from the instruction field decoder, plus the ALU zero flag and the memory ready handshake.
- Produces every datapath enable and mux select, a retired-instruction counter, and halt/error status.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- MEM_TIMEOUT, 255, maximum cycles to wait for mem_ready before declaring bus error (1..2^16-1).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26] from decoder
- ins_zero  in  1  1 when IR == 0 (NOP)
- alu_zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write  out  1  load PC
- pc_src  out  1  0 = ALU result (PC+4), 1 = ALUOut register (branch/jump target)
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read, mem_write  out  1 each  memory request, held until mem_ready
- ir_write  out  1  load IR
- reg_dst  out  1  1 = reg3 (R-type), 0 = reg2 (I-type)
- mem_to_reg  out  1  write-back source: 1 = MDR
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = reg1 data
- alu_src_b  out  2  0 = reg2 data, 1 = const 4, 2 = imm, 3 = imm<<2
- alu_op  out  4  0000 ADD, 0001 SUB, others pass-through opcode bits
- state  out  4  current state encoding
- retired  out  CNT_W  retired-instruction count
- halted  out  1  in HALT
- bus_error  out  1  sticky, timeout occurred
- illegal_op  out  1  one-cycle pulse in DECODE for an undefined opcode

Behaviour:
- Opcode map:
  - opcode[5:4] = 00: R-ALU, alu_op = opcode[3:0].
  - 010xxx: I-ALU, alu_op = {0, opcode[2:0]}.
  - 011000 LW; 011001 SW; 011010 BEQ; 011011 BNE; 011100 JMP; 111111 HALT.
  - All other opcodes are illegal.
- State encoding: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, HALT=10.
- Reset (async, rst_n=0):
  - state=FETCH; retired=0; bus_error=0.
  - All outputs are 0 except mem_read=1 and alu_src_b=1, which are driven from state FETCH.
  - Reset mid-instruction abandons it: no reg_write or mem_write is issued after reset asserts.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0. In the cycle mem_ready=1, ir_write=1 and pc_write=1 (Mealy), then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (ALUOut latches the branch target). Next state:
  - ins_zero or illegal opcode → FETCH, retired+1 (illegal_op=1 if illegal).
  - R-ALU → EXEC_R.
  - I-ALU → EXEC_I.
  - LW/SW → MEM_ADDR.
  - BEQ/BNE/JMP → BRANCH.
  - HALT → HALT.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op from opcode → WB_ALU with reg_dst=1.
- EXEC_I: alu_src_a=1, alu_src_b=2 → WB_ALU with reg_dst=0.
- WB_ALU: reg_write=1, mem_to_reg=0, reg_dst held per instruction class → FETCH, retired+1.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: iord=1, mem_read=1; on mem_ready → WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH, retired+1.
- MEM_WR: iord=1, mem_write=1; on mem_ready → FETCH, retired+1.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1. pc_write = JMP | (BEQ & alu_zero) | (BNE & ~alu_zero). → FETCH, retired+1.
- HALT: terminal; halted=1; all enables 0; exit only via reset.
- Memory wait:
  - A wait counter clears on entry to FETCH, MEM_RD or MEM_WR and increments each cycle mem_ready=0.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0: set bus_error, go to HALT. No ir_write, reg_write or pc_write is issued.
  - mem_ready when no request is outstanding is ignored.
- Retired counter wraps modulo 2^CNT_W.
- Latency with zero-wait memory:
  - R/I-ALU: 4 cycles. LW: 5. SW: 4. Branch/jump: 3. NOP: 2.
- Opcode is sampled in DECODE and in later states; it must stay stable (IR is not written outside FETCH).

Test Plan:
- Reset with rst_n=0 mid-MEM_WR → state=0 immediately (async), mem_write=0, retired=0; after release, FETCH issues mem_read=1.
- R-type opcode 000010, ins_zero=0, mem_ready=1 → states 0,1,2,7,0; reg_write=1 only in state 7 with reg_dst=1; alu_op=0010 in state 2; retired=1.
- LW (011000) with mem_ready held low 3 cycles in MEM_RD → MEM_RD occupies 4 cycles, WB_MEM asserts reg_write=1 and mem_to_reg=1; total 8 cycles.
- BEQ (011010) alu_zero=1 → pc_write=1 with pc_src=1 in BRANCH. Repeat with alu_zero=0 → pc_write=0. BNE gives the inverse results.
- Illegal opcode 100000 → illegal_op pulses for 1 cycle in DECODE, return to FETCH, retired increments. ins_zero=1 → NOP, 2 cycles.
- MEM_TIMEOUT=4, mem_ready=0 forever in FETCH → after 4 wait cycles bus_error=1, halted=1, state=10; no ir_write ever asserted. Opcode 111111 → HALT with bus_error=0.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_controller
// Purpose : Control FSM sequencing a shared multi-cycle datapath (PC, IR, ALU,
//           single memory port, register file) with memory-timeout handling.
// Revision: 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode_i,
  input  logic             ins_zero_i,
  input  logic             alu_zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [3:0]       alu_op_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired_o,
  output logic             halted_o,
  output logic             bus_error_o,
  output logic             illegal_op_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_WB_ALU   = 4'd7;
  localparam logic [3:0] S_WB_MEM   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_HALT     = 4'd10;

  localparam logic [3:0]  c_ALU_ADD = 4'b0000;
  localparam logic [3:0]  c_ALU_SUB = 4'b0001;
  localparam logic [15:0] c_TO_LAST = 16'(MEM_TIMEOUT - 1);

  logic [3:0]       state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             bus_error_q, bus_error_d;
  logic             retire_w;

  logic w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_beq, w_is_bne, w_is_jmp, w_is_halt;
  logic w_illegal, w_taken, w_mem_wait, w_timeout;

  assign w_is_r    = (opcode_i[5:4] == 2'b00);
  assign w_is_i    = (opcode_i[5:3] == 3'b010);
  assign w_is_lw   = (opcode_i == 6'b011000);
  assign w_is_sw   = (opcode_i == 6'b011001);
  assign w_is_beq  = (opcode_i == 6'b011010);
  assign w_is_bne  = (opcode_i == 6'b011011);
  assign w_is_jmp  = (opcode_i == 6'b011100);
  assign w_is_halt = (opcode_i == 6'b111111);
  assign w_illegal = ~(w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_beq |
                       w_is_bne | w_is_jmp | w_is_halt);
  assign w_taken   = w_is_jmp | (w_is_beq & alu_zero_i) | (w_is_bne & ~alu_zero_i);

  // Only states with an outstanding memory request can time out.
  assign w_mem_wait = (state_q == S_FETCH) | (state_q == S_MEM_RD) | (state_q == S_MEM_WR);
  assign w_timeout  = w_mem_wait & ~mem_ready_i & (wait_q == c_TO_LAST);

  always_comb begin
    state_d  = state_q;
    retire_w = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready_i)    state_d = S_DECODE;
        else if (w_timeout) state_d = S_HALT;
      end
      S_DECODE: begin
        if (ins_zero_i || w_illegal) begin
          state_d  = S_FETCH;
          retire_w = 1'b1;
        end
        else if (w_is_r)                        state_d = S_EXEC_R;
        else if (w_is_i)                        state_d = S_EXEC_I;
        else if (w_is_lw || w_is_sw)            state_d = S_MEM_ADDR;
        else if (w_is_beq || w_is_bne || w_is_jmp) state_d = S_BRANCH;
        else                                    state_d = S_HALT;
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADDR:         state_d = w_is_lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready_i)    state_d = S_WB_MEM;
        else if (w_timeout) state_d = S_HALT;
      end
      S_MEM_WR: begin
        if (mem_ready_i) begin
          state_d  = S_FETCH;
          retire_w = 1'b1;
        end
        else if (w_timeout) state_d = S_HALT;
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH: begin
        state_d  = S_FETCH;
        retire_w = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // The wait counter restarts whenever a new state is entered.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)            wait_d = 16'd0;
    else if (w_mem_wait && !mem_ready_i) wait_d = wait_q + 16'd1;
  end

  assign retired_d   = retire_w ? retired_q + CNT_W'(1) : retired_q;
  assign bus_error_d = bus_error_q | w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      wait_q      <= 16'd0;
      retired_q   <= '0;
      bus_error_q <= 1'b0;
    end
    else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      retired_q   <= retired_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    pc_write_o   = 1'b0;
    pc_src_o     = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'd0;
    alu_op_o     = c_ALU_ADD;
    halted_o     = 1'b0;
    illegal_op_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'd1;
        // Gated so a ready strobe seen during reset cannot load IR/PC.
        ir_write_o  = mem_ready_i & rst_n;
        pc_write_o  = mem_ready_i & rst_n;
      end
      S_DECODE: begin
        alu_src_b_o  = 2'd3;
        illegal_op_o = ~ins_zero_i & w_illegal;
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = opcode_i[3:0];
        reg_dst_o   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        alu_op_o    = {1'b0, opcode_i[2:0]};
      end
      S_WB_ALU: begin
        reg_write_o = 1'b1;
        reg_dst_o   = w_is_r;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
      end
      S_MEM_RD: begin
        iord_o     = 1'b1;
        mem_read_o = 1'b1;
      end
      S_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEM_WR: begin
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = c_ALU_SUB;
        pc_src_o    = 1'b1;
        pc_write_o  = w_taken;
      end
      S_HALT:  halted_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o     = state_q;
  assign retired_o   = retired_q;
  assign bus_error_o = bus_error_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_controller
// Purpose : Directed and random checks of multicycle_controller against a
//           per-instruction cycle-trace model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
                         S_MEM_ADDR = 4'd4, S_MEM_RD = 4'd5, S_MEM_WR = 4'd6, S_WB_ALU = 4'd7,
                         S_WB_MEM = 4'd8, S_BRANCH = 4'd9, S_HALT = 4'd10;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_NOP = 5, K_ILL = 6, K_HALT = 7;

  localparam logic [5:0] OP_LW = 6'b011000, OP_SW = 6'b011001, OP_BEQ = 6'b011010,
                         OP_BNE = 6'b011011, OP_JMP = 6'b011100, OP_HALT = 6'b111111;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [5:0] opcode = '0;
  logic ins_zero = 1'b0, alu_zero = 1'b0, mem_ready = 1'b0;
  logic pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic alu_src_a, halted, bus_error, illegal_op;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op, state;
  logic [CNT_W-1:0] retired;

  multicycle_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .ins_zero_i(ins_zero),
    .alu_zero_i(alu_zero), .mem_ready_i(mem_ready),
    .pc_write_o(pc_write), .pc_src_o(pc_src), .iord_o(iord), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .ir_write_o(ir_write), .reg_dst_o(reg_dst),
    .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .state_o(state), .retired_o(retired),
    .halted_o(halted), .bus_error_o(bus_error), .illegal_op_o(illegal_op)
  );

  always #5 clk = ~clk;

  // One expected clock cycle of an instruction.
  typedef struct {
    logic [3:0] st;
    logic       free;
    logic       rdy;
    logic       rw, mw, pw, iw, ill, be;
    logic       rd, m2r, psrc;
    logic       chk_aop;
    logic [3:0] aop;
  } cyc_t;

  cyc_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc_idx = 0;
  logic [CNT_W-1:0] exp_ret = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s (cycle %0d): observed=%0h expected=%0h", tag, cyc_idx, obs, exp);
  endtask

  function automatic cyc_t mk(input logic [3:0] st);
    cyc_t c;
    c.st = st; c.free = 1'b1; c.rdy = 1'b0;
    c.rw = 0; c.mw = 0; c.pw = 0; c.iw = 0; c.ill = 0; c.be = 0;
    c.rd = 0; c.m2r = 0; c.psrc = 0; c.chk_aop = 0; c.aop = 4'd0;
    return c;
  endfunction

  function automatic int kind_of(input logic [5:0] op, input logic iz);
    if (iz) return K_NOP;
    if (op[5:4] == 2'b00) return K_R;
    if (op[5:3] == 3'b010) return K_I;
    case (op)
      OP_LW:                  return K_LW;
      OP_SW:                  return K_SW;
      OP_BEQ, OP_BNE, OP_JMP: return K_BR;
      OP_HALT:                return K_HALT;
      default:                return K_ILL;
    endcase
  endfunction

  // Expected cycle trace: fw/mwt are the number of not-ready memory cycles.
  task automatic build(input logic [5:0] op, input logic iz, input logic az,
                       input int fw, input int mwt);
    cyc_t c;
    int k;
    k = kind_of(op, iz);
    q.delete();
    for (int i = 0; i < fw; i++) begin
      c = mk(S_FETCH); c.free = 0; q.push_back(c);
    end
    c = mk(S_FETCH); c.free = 0; c.rdy = 1; c.pw = 1; c.iw = 1; q.push_back(c);
    c = mk(S_DECODE); c.ill = (k == K_ILL); c.chk_aop = 1; q.push_back(c);
    case (k)
      K_R: begin
        c = mk(S_EXEC_R); c.chk_aop = 1; c.aop = op[3:0]; q.push_back(c);
        c = mk(S_WB_ALU); c.rw = 1; c.rd = 1; q.push_back(c);
      end
      K_I: begin
        c = mk(S_EXEC_I); c.chk_aop = 1; c.aop = {1'b0, op[2:0]}; q.push_back(c);
        c = mk(S_WB_ALU); c.rw = 1; c.rd = 0; q.push_back(c);
      end
      K_LW: begin
        c = mk(S_MEM_ADDR); c.chk_aop = 1; q.push_back(c);
        for (int i = 0; i < mwt; i++) begin
          c = mk(S_MEM_RD); c.free = 0; q.push_back(c);
        end
        c = mk(S_MEM_RD); c.free = 0; c.rdy = 1; q.push_back(c);
        c = mk(S_WB_MEM); c.rw = 1; c.m2r = 1; q.push_back(c);
      end
      K_SW: begin
        c = mk(S_MEM_ADDR); c.chk_aop = 1; q.push_back(c);
        for (int i = 0; i < mwt; i++) begin
          c = mk(S_MEM_WR); c.free = 0; c.mw = 1; q.push_back(c);
        end
        c = mk(S_MEM_WR); c.free = 0; c.rdy = 1; c.mw = 1; q.push_back(c);
      end
      K_BR: begin
        c = mk(S_BRANCH); c.psrc = 1; c.chk_aop = 1; c.aop = 4'b0001;
        c.pw = (op == OP_JMP) || (op == OP_BEQ && az) || (op == OP_BNE && !az);
        q.push_back(c);
      end
      K_HALT: begin
        for (int i = 0; i < 3; i++) begin
          c = mk(S_HALT); q.push_back(c);
        end
      end
      default: ;
    endcase
  endtask

  // Entered and left at posedge+1; compares at the negedge.
  task automatic run_q(input int n);
    int lim;
    lim = (n < 0) ? q.size() : n;
    for (int i = 0; i < lim; i++) begin
      mem_ready = q[i].free ? 1'($urandom_range(0, 1)) : q[i].rdy;
      @(negedge clk);
      chk("state", 32'(state), 32'(q[i].st));
      chk("reg_write", 32'(reg_write), 32'(q[i].rw));
      chk("mem_write", 32'(mem_write), 32'(q[i].mw));
      chk("pc_write", 32'(pc_write), 32'(q[i].pw));
      chk("ir_write", 32'(ir_write), 32'(q[i].iw));
      chk("illegal_op", 32'(illegal_op), 32'(q[i].ill));
      chk("bus_error", 32'(bus_error), 32'(q[i].be));
      chk("mem_read", 32'(mem_read), 32'(q[i].st == S_FETCH || q[i].st == S_MEM_RD));
      chk("halted", 32'(halted), 32'(q[i].st == S_HALT));
      if (q[i].rw) begin
        chk("reg_dst", 32'(reg_dst), 32'(q[i].rd));
        chk("mem_to_reg", 32'(mem_to_reg), 32'(q[i].m2r));
      end
      if (q[i].st == S_BRANCH) chk("pc_src", 32'(pc_src), 32'(q[i].psrc));
      if (q[i].chk_aop) chk("alu_op", 32'(alu_op), 32'(q[i].aop));
      cyc_idx++;
      @(posedge clk); #1;
    end
  endtask

  task automatic exec(input logic [5:0] op, input logic iz, input logic az,
                      input int fw, input int mwt);
    opcode = op; ins_zero = iz; alu_zero = az;
    build(op, iz, az, fw, mwt);
    run_q(-1);
    if (kind_of(op, iz) != K_HALT) begin
      exp_ret = exp_ret + 1'b1;
      chk("retired", 32'(retired), 32'(exp_ret));
    end
  endtask

  // Asserts reset, checks the reset-state outputs, releases at posedge+1.
  task automatic do_reset();
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'(S_FETCH));
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd1);
    chk("rst_alu_src_b", 32'(alu_src_b), 32'd1);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_ir_write", 32'(ir_write), 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ret = '0;
  endtask

  initial begin
    logic [5:0] ill_ops [6];
    cyc_t c;
    ill_ops = '{6'b100000, 6'b011101, 6'b011110, 6'b011111, 6'b110000, 6'b111110};
    #2;
    do_reset();

    exec(6'b000010, 1'b0, 1'b0, 0, 0);   // R-type, 4 cycles
    exec(OP_LW, 1'b0, 1'b0, 0, 3);       // LW with 3 wait cycles, 8 cycles
    exec(OP_BEQ, 1'b0, 1'b1, 0, 0);
    exec(OP_BEQ, 1'b0, 1'b0, 0, 0);
    exec(OP_BNE, 1'b0, 1'b1, 0, 0);
    exec(OP_BNE, 1'b0, 1'b0, 0, 0);
    exec(OP_JMP, 1'b0, 1'b0, 1, 0);
    exec(6'b100000, 1'b0, 1'b0, 0, 0);   // illegal
    exec(6'b000000, 1'b1, 1'b0, 0, 0);   // NOP
    exec(OP_SW, 1'b0, 1'b0, 2, 1);
    exec(6'b010101, 1'b0, 1'b0, 0, 0);   // I-type

    // Random instruction mix; retired wraps past 2^CNT_W.
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      logic iz;
      int sel;
      sel = $urandom_range(0, 8);
      iz = 1'b0;
      case (sel)
        0: op = {2'b00, 4'($urandom_range(0, 15))};
        1: op = {3'b010, 3'($urandom_range(0, 7))};
        2: op = OP_LW;
        3: op = OP_SW;
        4: op = OP_BEQ;
        5: op = OP_BNE;
        6: op = OP_JMP;
        7: begin op = 6'b000000; iz = 1'b1; end
        default: op = ill_ops[$urandom_range(0, 5)];
      endcase
      exec(op, iz, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset in the middle of a store: write must drop immediately.
    opcode = OP_SW; ins_zero = 1'b0;
    build(OP_SW, 1'b0, 1'b0, 0, 3);
    run_q(3);
    mem_ready = 1'b0;
    #1;
    chk("sw_before_rst_state", 32'(state), 32'(S_MEM_WR));
    chk("sw_before_rst_mem_write", 32'(mem_write), 32'd1);
    do_reset();
    exec(6'b001111, 1'b0, 1'b0, 0, 0);

    // HALT opcode: halts without bus error.
    do_reset();
    exec(OP_HALT, 1'b0, 1'b0, 0, 0);
    chk("halt_retired", 32'(retired), 32'd0);

    // Fetch never completes: timeout after MEM_TIMEOUT waiting cycles.
    do_reset();
    opcode = 6'b000001;
    q.delete();
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      c = mk(S_FETCH); c.free = 0; q.push_back(c);
    end
    for (int i = 0; i < 3; i++) begin
      c = mk(S_HALT); c.be = 1; q.push_back(c);
    end
    run_q(-1);
    chk("timeout_retired", 32'(retired), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
